// File: rtl/contador_monitor.sv
// Sequence monitor for a free-running binary counter: checks +1 steps, counts
// legal wraps, flags discontinuities and drives a hex 7-segment digit.
module contador_monitor #(
  parameter int WIDTH          = 4,
  parameter int WRAP_W         = 8,
  parameter bit HOLD_OK        = 1'b0,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  q_in,
  input  logic              clr_err,
  output logic [WIDTH-1:0]  q_reg,
  output logic [6:0]        seg,
  output logic              wrap,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              err,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    SYNC  = 2'b00,
    TRACK = 2'b01,
    FAULT = 2'b10
  } state_e;

  localparam logic [WIDTH-1:0]  Q_ONE   = WIDTH'(1);
  localparam logic [WIDTH-1:0]  Q_MAX   = '1;
  localparam logic [WRAP_W-1:0] CNT_ONE = WRAP_W'(1);
  localparam logic [WRAP_W-1:0] CNT_MAX = '1;

  state_e              state_q;
  logic [WIDTH-1:0]    prev_q;
  logic [WIDTH-1:0]    q_reg_q;
  logic [6:0]          seg_q;
  logic                wrap_q;
  logic [WRAP_W-1:0]   wrap_cnt_q;
  logic                err_q;

  logic [WIDTH-1:0]    exp_d;
  logic                step_d;
  logic                legal_d;
  logic                is_wrap_d;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] p;
    case (v)
      4'h0: p = 7'b0111111;
      4'h1: p = 7'b0000110;
      4'h2: p = 7'b1011011;
      4'h3: p = 7'b1001111;
      4'h4: p = 7'b1100110;
      4'h5: p = 7'b1101101;
      4'h6: p = 7'b1111101;
      4'h7: p = 7'b0000111;
      4'h8: p = 7'b1111111;
      4'h9: p = 7'b1101111;
      4'hA: p = 7'b1110111;
      4'hB: p = 7'b1111100;
      4'hC: p = 7'b0111001;
      4'hD: p = 7'b1011110;
      4'hE: p = 7'b1111001;
      default: p = 7'b1110001;
    endcase
    return p;
  endfunction

  function automatic logic [6:0] seg_drive(input logic [3:0] v);
    return SEG_ACTIVE_LOW ? ~hex7(v) : hex7(v);
  endfunction

  // A stall only counts as legal when the build allows holds.
  always_comb begin
    exp_d     = prev_q + Q_ONE;
    step_d    = (q_in == exp_d);
    legal_d   = step_d || (HOLD_OK && (q_in == prev_q));
    is_wrap_d = step_d && (prev_q == Q_MAX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= SYNC;
      prev_q     <= '0;
      q_reg_q    <= '0;
      seg_q      <= seg_drive(4'h0);
      wrap_q     <= 1'b0;
      wrap_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      prev_q  <= q_in;
      q_reg_q <= q_in;
      seg_q   <= seg_drive(q_in);
      wrap_q  <= 1'b0;
      case (state_q)
        SYNC: state_q <= TRACK;
        TRACK: begin
          if (!legal_d) begin
            state_q <= FAULT;
            err_q   <= 1'b1;
          end else if (is_wrap_d) begin
            wrap_q <= 1'b1;
            if (wrap_cnt_q != CNT_MAX) wrap_cnt_q <= wrap_cnt_q + CNT_ONE;
          end
        end
        FAULT: begin
          if (clr_err) begin
            state_q <= SYNC;
            err_q   <= 1'b0;
          end
        end
        default: state_q <= SYNC;
      endcase
    end
  end

  assign q_reg    = q_reg_q;
  assign seg      = seg_q;
  assign wrap     = wrap_q;
  assign wrap_cnt = wrap_cnt_q;
  assign err      = err_q;
  assign state    = state_q;

endmodule

// File: tb/tb_contador_monitor.sv
// Bench for contador_monitor: three builds (default, HOLD_OK=1, WRAP_W=2) share
// one stimulus stream and are checked every cycle against a behavioural model.
module tb_contador_monitor;

  logic       clk = 1'b1;
  logic       rst = 1'b0;
  logic [3:0] q_in = 4'h0;
  logic       clr_err = 1'b0;

  logic [2:0][3:0] qr;
  logic [2:0][6:0] sg;
  logic [2:0]      wr;
  logic [2:0][7:0] wc;
  logic [2:0]      er;
  logic [2:0][1:0] st;
  logic [1:0]      wc2;

  int n_vec = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  contador_monitor #(.WIDTH(4), .WRAP_W(8), .HOLD_OK(1'b0), .SEG_ACTIVE_LOW(1'b1)) dut0 (
    .clk(clk), .rst(rst), .q_in(q_in), .clr_err(clr_err), .q_reg(qr[0]), .seg(sg[0]),
    .wrap(wr[0]), .wrap_cnt(wc[0]), .err(er[0]), .state(st[0]));

  contador_monitor #(.WIDTH(4), .WRAP_W(8), .HOLD_OK(1'b1), .SEG_ACTIVE_LOW(1'b1)) dut1 (
    .clk(clk), .rst(rst), .q_in(q_in), .clr_err(clr_err), .q_reg(qr[1]), .seg(sg[1]),
    .wrap(wr[1]), .wrap_cnt(wc[1]), .err(er[1]), .state(st[1]));

  contador_monitor #(.WIDTH(4), .WRAP_W(2), .HOLD_OK(1'b0), .SEG_ACTIVE_LOW(1'b1)) dut2 (
    .clk(clk), .rst(rst), .q_in(q_in), .clr_err(clr_err), .q_reg(qr[2]), .seg(sg[2]),
    .wrap(wr[2]), .wrap_cnt(wc2), .err(er[2]), .state(st[2]));

  assign wc[2] = {6'b0, wc2};

  // Active-high hex digit patterns, gfedcba.
  logic [6:0] hex_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  function automatic logic [6:0] exp_seg(input int v);
    logic [6:0] p;
    p = hex_tbl[v];
    return ~p;
  endfunction

  function automatic int cap_of(input int c);
    return (c == 2) ? 3 : 255;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // Model: mode 0=sync, 1=track, 2=fault; wraps is an unbounded tally.
  int m_mode [3];
  int m_prev [3];
  int m_qreg [3];
  int m_wraps[3];
  int m_err  [3];
  int m_wrap [3];

  initial begin
    for (int c = 0; c < 3; c++) begin
      m_mode[c] = 0; m_prev[c] = 0; m_qreg[c] = 0;
      m_wraps[c] = 0; m_err[c] = 0; m_wrap[c] = 0;
    end
  end

  always @(posedge clk or posedge rst) begin : model
    int v;
    for (int c = 0; c < 3; c++) begin
      if (rst) begin
        m_mode[c] = 0; m_prev[c] = 0; m_qreg[c] = 0;
        m_wraps[c] = 0; m_err[c] = 0; m_wrap[c] = 0;
      end else begin
        v = int'(q_in);
        m_wrap[c] = 0;
        if (m_mode[c] == 0) begin
          m_mode[c] = 1;
        end else if (m_mode[c] == 1) begin
          if (v == (m_prev[c] + 1) % 16) begin
            if (m_prev[c] == 15) begin
              m_wrap[c] = 1;
              m_wraps[c]++;
            end
          end else if (!(c == 1 && v == m_prev[c])) begin
            m_mode[c] = 2;
            m_err[c]  = 1;
          end
        end else if (clr_err) begin
          m_mode[c] = 0;
          m_err[c]  = 0;
        end
        m_prev[c] = v;
        m_qreg[c] = v;
      end
    end
  end

  always @(negedge clk) begin
    for (int c = 0; c < 3; c++) begin
      check($sformatf("c%0d.q_reg", c), 32'(qr[c]), m_qreg[c]);
      check($sformatf("c%0d.seg", c), 32'(sg[c]), 32'(exp_seg(m_qreg[c])));
      check($sformatf("c%0d.wrap", c), 32'(wr[c]), m_wrap[c]);
      check($sformatf("c%0d.wrap_cnt", c), 32'(wc[c]),
            (m_wraps[c] < cap_of(c)) ? m_wraps[c] : cap_of(c));
      check($sformatf("c%0d.err", c), 32'(er[c]), m_err[c]);
      check($sformatf("c%0d.state", c), 32'(st[c]), m_mode[c]);
    end
  end

  task automatic apply(input int v, input logic clr);
    q_in    = 4'(v);
    clr_err = clr;
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    #2 rst = 1'b1;
    #1;
    #1 rst = 1'b0;
  endtask

  int sat_exp [5] = '{1, 2, 3, 3, 3};
  int pulses;
  int cur;
  int r;
  logic clr_r;

  initial begin
    #1 rst = 1'b1;
    #2;
    check("rst.q_reg", 32'(qr[0]), 32'h0);
    check("rst.seg", 32'(sg[0]), 32'h40);
    check("rst.state", 32'(st[0]), 32'h0);
    check("rst.wrap_cnt", 32'(wc[0]), 32'h0);
    #13 rst = 1'b0;

    // Free run 0..15, 0..3
    for (int i = 0; i < 20; i++) begin
      apply(i % 16, 1'b0);
      if (i == 0)  check("run.state_track", 32'(st[0]), 32'h1);
      if (i == 10) check("run.seg_A", 32'(sg[0]), 32'h08);
      if (i == 16) check("run.wrap_pulse", 32'(wr[0]), 32'h1);
      if (i == 17) check("run.wrap_drop", 32'(wr[0]), 32'h0);
    end
    check("run.wrap_cnt", 32'(wc[0]), 32'h1);
    check("run.err", 32'(er[0]), 32'h0);

    // Asynchronous reset while q_reg shows 9
    for (int v = 4; v <= 9; v++) apply(v, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("arst.q_reg", 32'(qr[0]), 32'h0);
    check("arst.seg", 32'(sg[0]), 32'h40);
    check("arst.wrap_cnt", 32'(wc[0]), 32'h0);
    check("arst.state", 32'(st[0]), 32'h0);
    #1 rst = 1'b0;
    apply(0, 1'b0);
    check("arst.resume_state", 32'(st[0]), 32'h1);

    // Skip 4 -> 6, then a suppressed wrap
    for (int v = 1; v <= 4; v++) apply(v, 1'b0);
    apply(6, 1'b0);
    check("skip.err", 32'(er[0]), 32'h1);
    check("skip.state", 32'(st[0]), 32'h2);
    for (int v = 7; v <= 16; v++) apply(v % 16, 1'b0);
    check("skip.no_wrap", 32'(wr[0]), 32'h0);
    check("skip.cnt_frozen", 32'(wc[0]), 32'h0);

    // Recovery, clr_err ignored in TRACK, error beats clr_err
    apply(1, 1'b1);
    check("rec.state_sync", 32'(st[0]), 32'h0);
    check("rec.err_clr", 32'(er[0]), 32'h0);
    apply(5, 1'b0);
    apply(6, 1'b1);
    check("rec.track_clr", 32'(st[0]), 32'h1);
    apply(3, 1'b1);
    check("rec.err_wins", 32'(st[0]), 32'h2);
    apply(0, 1'b1);

    // Stall 5,5,6
    apply(4, 1'b0);
    apply(5, 1'b0);
    apply(5, 1'b0);
    apply(6, 1'b0);
    check("stall.hold0_err", 32'(er[0]), 32'h1);
    check("stall.hold1_err", 32'(er[1]), 32'h0);
    check("stall.hold1_state", 32'(st[1]), 32'h1);

    // Saturation on the 2-bit wrap counter
    pulse_reset();
    apply(0, 1'b0);
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      for (int v = 1; v <= 15; v++) apply(v, 1'b0);
      apply(0, 1'b0);
      if (wr[2]) pulses++;
      check($sformatf("sat.cnt%0d", k), 32'(wc[2]), sat_exp[k]);
    end
    check("sat.pulses", pulses, 5);
    check("sat.wide_cnt", 32'(wc[0]), 32'h5);

    // Randomized run: mostly counting, with jumps, stalls, clears and resets
    cur = 0;
    for (int i = 0; i < 400; i++) begin
      r     = int'($urandom_range(0, 99));
      clr_r = ($urandom_range(0, 19) == 0);
      if (r < 3) begin
        pulse_reset();
        cur = 0;
      end else if (r < 10) begin
        cur = int'($urandom_range(0, 15));
      end else if (r < 16) begin
        cur = cur;
      end else begin
        cur = (cur + 1) % 16;
      end
      apply(cur, clr_r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
